// File: rtl/inst_fetch_pkg.sv
// Shared constants and state encoding for the stage-1 instruction fetch controller.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        FetchEmpty = 2'd0,
        FetchPend  = 2'd1,
        FetchHold  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_2000;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instruction+PC holding register with load enable and synchronous clear.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] d_inst,
    input  logic [31:0] d_pc,
    output logic [31:0] q_inst,
    output logic [31:0] q_pc
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q_inst <= '0;
            q_pc   <= '0;
        end else if (load) begin
            q_inst <= d_inst;
            q_pc   <= d_pc;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Stage-1 fetch controller: issues cache reads at the PC, absorbs misses, buffers the
// returned instruction while stage 2 stalls, and squashes wrong-path fetches after a kill.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP      = INST_NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_out,
    input  logic        kill,
    input  logic        stall_in,
    output logic [31:0] icache_addr,
    output logic        icache_re,
    input  logic [31:0] icache_dout,
    input  logic        icache_stall,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        fetch_stall
);

    fetch_state_e state_q, state_d;
    logic         kill_q, kill_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         hold_load;
    logic [31:0]  hold_inst, hold_pc;

    assign icache_addr = pc_out;

    fetch_hold_buf u_hold_buf (
        .clk    (clk),
        .clear  (reset),
        .load   (hold_load),
        .d_inst (icache_dout),
        .d_pc   (req_pc_q),
        .q_inst (hold_inst),
        .q_pc   (hold_pc)
    );

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        req_pc_d    = req_pc_q;
        hold_load   = 1'b0;
        icache_re   = 1'b0;
        fetch_stall = 1'b0;
        inst_valid  = 1'b0;
        inst        = NOP;
        inst_pc     = PC_RESET;

        if (!reset) begin
            unique case (state_q)
                FetchEmpty: begin
                    icache_re = 1'b1;
                    req_pc_d  = pc_out;
                    state_d   = FetchPend;
                end
                FetchPend: begin
                    inst_pc = req_pc_q;
                    if (icache_stall) begin
                        fetch_stall = 1'b1;
                    end else if (kill_q || kill) begin
                        // Wrong-path response: drop it and keep fetching.
                        icache_re = 1'b1;
                        req_pc_d  = pc_out;
                        kill_d    = 1'b0;
                    end else if (stall_in) begin
                        inst        = icache_dout;
                        inst_valid  = 1'b1;
                        fetch_stall = 1'b1;
                        hold_load   = 1'b1;
                        state_d     = FetchHold;
                    end else begin
                        inst       = icache_dout;
                        inst_valid = 1'b1;
                        icache_re  = 1'b1;
                        req_pc_d   = pc_out;
                    end
                end
                FetchHold: begin
                    inst_pc = hold_pc;
                    if (stall_in) begin
                        inst        = hold_inst;
                        inst_valid  = 1'b1;
                        fetch_stall = 1'b1;
                    end else begin
                        icache_re = 1'b1;
                        req_pc_d  = pc_out;
                        state_d   = FetchPend;
                        if (!kill) begin
                            inst       = hold_inst;
                            inst_valid = 1'b1;
                        end
                    end
                end
                default: state_d = FetchEmpty;
            endcase

            // A new kill wins over clearing, since its own wrong-path request is now in flight.
            if (kill && !fetch_stall) begin
                kill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FetchEmpty;
            kill_q   <= 1'b0;
            req_pc_q <= PC_RESET;
        end else begin
            state_q  <= state_d;
            kill_q   <= kill_d;
            req_pc_q <= req_pc_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: PC register and cache environment, a program-order
// stream model checked every cycle, and directed literal expectations.
module tb_inst_fetch;

    localparam logic [31:0] PC_RST = 32'h0000_2000;
    localparam logic [31:0] NOPW   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_out = PC_RST;
    logic        kill = 1'b0;
    logic        stall_in = 1'b0;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout = 32'hDEAD_BEEF;
    logic        icache_stall = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        fetch_stall;

    inst_fetch #(
        .PC_RESET (PC_RST),
        .NOP      (NOPW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_out       (pc_out),
        .kill         (kill),
        .stall_in     (stall_in),
        .icache_addr  (icache_addr),
        .icache_re    (icache_re),
        .icache_dout  (icache_dout),
        .icache_stall (icache_stall),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_valid   (inst_valid),
        .fetch_stall  (fetch_stall)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Environment state: PC register and the cache's last accepted read address.
    logic [31:0] pc_reg = PC_RST;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] kill_target = 32'h0;

    // Per-cycle snapshot for literal expectations.
    logic        s_valid, s_re, s_fs;
    logic [31:0] s_pc, s_inst, s_addr, s_pcout;

    // Stream model state.
    logic [31:0] exp_pc = PC_RST;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic rst, input logic ic_st, input logic st_in, input logic kl,
                        input logic [31:0] tgt);
        reset        = rst;
        icache_stall = ic_st;
        stall_in     = st_in;
        kill         = kl;
        kill_target  = tgt;
        pc_out       = pc_reg;
        icache_dout  = ic_st ? 32'hDEAD_BEEF : mem_word(last_addr);
        @(negedge clk);
        s_valid = inst_valid;
        s_re    = icache_re;
        s_fs    = fetch_stall;
        s_pc    = inst_pc;
        s_inst  = inst;
        s_addr  = icache_addr;
        s_pcout = pc_out;
        if (rst) begin
            pc_reg = PC_RST;
        end else begin
            if (icache_re) last_addr = pc_out;
            if (kl && !fetch_stall) pc_reg = tgt;
            else if (icache_re) pc_reg = pc_out + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_valid(input string name, input logic [31:0] pc);
        chk({name, "_valid"}, s_valid, 1'b1);
        chk({name, "_pc"}, s_pc, pc);
        chk({name, "_inst"}, s_inst, mem_word(pc));
    endtask

    task automatic expect_bubble(input string name);
        chk({name, "_valid"}, s_valid, 1'b0);
        chk({name, "_nop"}, s_inst, NOPW);
    endtask

    // Program-order model: accepted instructions must follow the correct path exactly.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_re", icache_re, 1'b0);
            chk("rst_valid", inst_valid, 1'b0);
            chk("rst_inst", inst, NOPW);
            chk("rst_pc", inst_pc, PC_RST);
            chk("rst_fstall", fetch_stall, 1'b0);
            exp_pc    = PC_RST;
            prev_hold = 1'b0;
        end else begin
            chk("addr_eq_pc", icache_addr, pc_out);
            chk("fstall_vs_re", fetch_stall, !icache_re);
            if (!inst_valid) chk("invalid_nop", inst, NOPW);
            else chk("inst_data", inst, mem_word(inst_pc));
            if (prev_hold && !(kill && !fetch_stall)) begin
                chk("hold_valid", inst_valid, 1'b1);
                chk("hold_pc", inst_pc, prev_pc);
            end
            if (kill && !fetch_stall) begin
                chk("kill_squash", inst_valid, 1'b0);
                exp_pc = kill_target;
            end else if (inst_valid && !stall_in) begin
                chk("stream_pc", inst_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            prev_hold = inst_valid && stall_in;
            prev_pc   = inst_pc;
        end
    end

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // First cycle after reset: read at PC_RESET, nothing valid yet.
        step(0, 0, 0, 0, 0);
        chk("c0_valid", s_valid, 1'b0);
        chk("c0_re", s_re, 1'b1);
        chk("c0_addr", s_addr, 32'h2000);
        step(0, 0, 0, 0, 0); expect_valid("hit0", 32'h2000);
        step(0, 0, 0, 0, 0); expect_valid("hit1", 32'h2004);
        step(0, 0, 0, 0, 0); expect_valid("hit2", 32'h2008);
        chk("hit2_next_req", s_pcout, 32'h200C);

        // Five-cycle miss on 0x200C.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0);
            expect_bubble("miss");
            chk("miss_fstall", s_fs, 1'b1);
            chk("miss_pc_frozen", s_pcout, 32'h2010);
        end
        step(0, 0, 0, 0, 0); expect_valid("miss_done", 32'h200C);

        // Stage 2 stalls for three cycles as 0x2010 returns.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0);
            expect_valid("hold", 32'h2010);
            chk("hold_re", s_re, 1'b0);
        end
        step(0, 0, 0, 0, 0);
        expect_valid("hold_release", 32'h2010);
        chk("hold_release_re", s_re, 1'b1);
        chk("hold_next_req", s_pcout, 32'h2014);

        // Kill with a response present: two bubbles, then the target.
        step(0, 0, 0, 1, 32'h3000);
        expect_bubble("kill_b0");
        chk("kill_b0_re", s_re, 1'b1);
        step(0, 0, 1, 0, 0);
        expect_bubble("kill_b1");
        chk("kill_b1_req", s_pcout, 32'h3000);
        step(0, 0, 0, 0, 0); expect_valid("kill_tgt", 32'h3000);

        // Kill followed by a four-cycle miss on the dropped request.
        step(0, 0, 0, 1, 32'h4000);
        expect_bubble("kmiss_k");
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 0);
            expect_bubble("kmiss_m");
            chk("kmiss_fstall", s_fs, 1'b1);
        end
        step(0, 0, 0, 0, 0);
        expect_bubble("kmiss_drop");
        chk("kmiss_req", s_pcout, 32'h4000);
        step(0, 0, 0, 0, 0); expect_valid("kmiss_tgt", 32'h4000);

        // Kill while an instruction is held.
        step(0, 0, 1, 0, 0); expect_valid("khold_h", 32'h4004);
        step(0, 0, 0, 1, 32'h5000);
        expect_bubble("khold_k");
        chk("khold_re", s_re, 1'b1);
        step(0, 0, 0, 0, 0); expect_bubble("khold_drop");
        step(0, 0, 0, 0, 0); expect_valid("khold_tgt", 32'h5000);

        // Both stalls together, then reset mid-miss with a stale response on the bus.
        step(0, 1, 0, 0, 0); expect_bubble("rmiss0");
        step(0, 1, 1, 0, 0);
        expect_bubble("rmiss1");
        chk("rmiss1_fstall", s_fs, 1'b1);
        step(1, 0, 0, 0, 0);
        expect_bubble("rst_mid");
        chk("rst_mid_pc", s_pc, PC_RST);
        step(0, 0, 0, 0, 0);
        expect_bubble("post_rst");
        chk("post_rst_re", s_re, 1'b1);
        chk("post_rst_addr", s_addr, 32'h2000);
        step(0, 0, 0, 0, 0); expect_valid("post_rst_hit0", 32'h2000);
        step(0, 0, 0, 0, 0); expect_valid("post_rst_hit1", 32'h2004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
